// File: rtl/sign_pkg.sv
// sign_pkg: shared lane width, parameter-set lookups and challenge-expansion FSM
// encoding for the signing pipeline.
package sign_pkg;

    localparam int unsigned LANE_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL_R,
        ST_FILL_EPS,
        ST_FLUSH,
        ST_DONE
    } chal_state_t;

    function automatic int unsigned sign_tau(input logic [15:0] ps);
        case (ps)
            "L3":    return 26;
            "L5":    return 34;
            default: return 17;
        endcase
    endfunction

    function automatic int unsigned sign_d_split(input logic [15:0] ps);
        case (ps)
            "L3", "L5": return 2;
            default:    return 1;
        endcase
    endfunction

    function automatic int unsigned sign_t(input logic [15:0] ps);
        case (ps)
            "L5":    return 4;
            default: return 3;
        endcase
    endfunction

endpackage

// File: rtl/chal_lane_packer.sv
// chal_lane_packer: assembles accepted 32-bit words into T-lane entries and
// issues one registered RAM write per completed entry.
module chal_lane_packer
    import sign_pkg::*;
#(
    parameter int unsigned T       = 3,
    parameter int unsigned ENTRIES = 17,
    localparam int unsigned AW     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
    localparam int unsigned LW     = (T > 1) ? $clog2(T) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  take,
    input  logic                  tag,
    input  logic [LANE_W-1:0]     word,
    output logic                  last,
    output logic                  wr_en,
    output logic                  wr_tag,
    output logic [AW-1:0]         wr_addr,
    output logic [T*LANE_W-1:0]   wr_data
);

    localparam logic [LW-1:0] LANE_LAST  = LW'(T - 1);
    localparam logic [AW-1:0] ENTRY_LAST = AW'(ENTRIES - 1);

    logic [LW-1:0]             lane_cnt;
    logic [AW-1:0]             entry_cnt;
    logic [(T-1)*LANE_W-1:0]   asm_q;

    // Next accepted word completes the whole vector.
    assign last = (lane_cnt == LANE_LAST) && (entry_cnt == ENTRY_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt  <= '0;
            entry_cnt <= '0;
            asm_q     <= '0;
            wr_en     <= 1'b0;
            wr_tag    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_en <= 1'b0;
            if (clear) begin
                lane_cnt  <= '0;
                entry_cnt <= '0;
            end else if (take) begin
                if (lane_cnt == LANE_LAST) begin
                    wr_en     <= 1'b1;
                    wr_tag    <= tag;
                    wr_addr   <= entry_cnt;
                    wr_data   <= {word, asm_q};
                    lane_cnt  <= '0;
                    entry_cnt <= (entry_cnt == ENTRY_LAST) ? '0 : entry_cnt + 1'b1;
                end else begin
                    for (int unsigned l = 0; l < T - 1; l++) begin
                        if (lane_cnt == LW'(l)) asm_q[l*LANE_W +: LANE_W] <= word;
                    end
                    lane_cnt <= lane_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sign_chal_expand.sv
// sign_chal_expand: packs the squeeze stream into the r and eps challenge stores
// and serves them on registered read ports. SIGN_CHAL_REJECT_EN enables r filtering.
module sign_chal_expand
    import sign_pkg::*;
#(
    parameter logic [15:0] PARAMETER_SET = "L1",
    parameter logic [39:0] FIELD         = "GF256",
    parameter int unsigned TAU           = sign_tau(PARAMETER_SET),
    parameter int unsigned D_SPLIT       = sign_d_split(PARAMETER_SET),
    parameter int unsigned T             = sign_t(PARAMETER_SET),
    parameter int unsigned N_CHAL        = TAU * D_SPLIT * T,
    parameter int unsigned ENTRIES       = TAU * D_SPLIT,
    localparam int unsigned AW           = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [31:0]          i_hash_data_out,
    input  logic                 i_hash_data_out_valid,
    output logic                 o_hash_data_out_ready,
    output logic                 o_hash_force_done,
    input  logic                 i_hash_force_done_ack,
    input  logic [AW-1:0]        i_r_addr,
    input  logic                 i_r_rd,
    output logic [T*LANE_W-1:0]  o_r,
    input  logic [AW-1:0]        i_eps_addr,
    input  logic                 i_eps_rd,
    output logic [T*LANE_W-1:0]  o_eps,
    output logic                 o_busy,
    output logic                 o_done
);

    if (FIELD != "GF256" || N_CHAL != ENTRIES * T || T < 2) begin : g_bad_cfg
        $error("sign_chal_expand: unsupported configuration");
    end

    chal_state_t            state;
    logic                   discard;
    logic                   take;
    logic                   last;
    logic                   clear;
    logic                   wr_en;
    logic                   wr_tag;
    logic [AW-1:0]          wr_addr;
    logic [T*LANE_W-1:0]    wr_data;
    logic [T*LANE_W-1:0]    r_mem   [ENTRIES];
    logic [T*LANE_W-1:0]    eps_mem [ENTRIES];

`ifdef SIGN_CHAL_REJECT_EN
    assign discard = (state == ST_FILL_R) && (i_hash_data_out[31:8] == '0);
`else
    assign discard = 1'b0;
`endif

    // Rejected words are still handshaken, they just never reach the packer.
    assign take  = i_hash_data_out_valid && o_hash_data_out_ready && !discard;
    assign clear = (state == ST_IDLE) && i_start;

    chal_lane_packer #(
        .T       (T),
        .ENTRIES (ENTRIES)
    ) u_packer (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .clear   (clear),
        .take    (take),
        .tag     (state == ST_FILL_EPS),
        .word    (i_hash_data_out),
        .last    (last),
        .wr_en   (wr_en),
        .wr_tag  (wr_tag),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state                 <= ST_IDLE;
            o_busy                <= 1'b0;
            o_done                <= 1'b0;
            o_hash_data_out_ready <= 1'b0;
            o_hash_force_done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state                 <= ST_FILL_R;
                        o_busy                <= 1'b1;
                        o_hash_data_out_ready <= 1'b1;
                    end
                end
                ST_FILL_R: begin
                    if (take && last) state <= ST_FILL_EPS;
                end
                ST_FILL_EPS: begin
                    if (take && last) begin
                        state                 <= ST_FLUSH;
                        o_hash_data_out_ready <= 1'b0;
                        o_hash_force_done     <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (i_hash_force_done_ack) begin
                        state             <= ST_DONE;
                        o_hash_force_done <= 1'b0;
                        o_done            <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            if (wr_tag) eps_mem[wr_addr] <= wr_data;
            else        r_mem[wr_addr]   <= wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_r   <= '0;
            o_eps <= '0;
        end else begin
            if (i_r_rd)   o_r   <= r_mem[i_r_addr];
            if (i_eps_rd) o_eps <= eps_mem[i_eps_addr];
        end
    end

endmodule

// File: tb/tb_sign_chal_expand.sv
// tb_sign_chal_expand: drives squeeze streams into sign_chal_expand (L1) and
// compares both challenge stores against a queue-based packing model.
`timescale 1ns/1ps
module tb_sign_chal_expand;

    localparam int unsigned T       = 3;
    localparam int unsigned ENTRIES = 17;
    localparam int unsigned N_CHAL  = 51;
    localparam int unsigned AW      = 5;
    localparam int unsigned EW      = T * 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   hdata = '0;
    logic          hvalid = 1'b0;
    logic          ready;
    logic          force_done;
    logic          ack = 1'b0;
    logic [AW-1:0] r_addr = '0;
    logic          r_rd = 1'b0;
    logic [EW-1:0] o_r;
    logic [AW-1:0] eps_addr = '0;
    logic          eps_rd = 1'b0;
    logic [EW-1:0] o_eps;
    logic          busy;
    logic          done;

    sign_chal_expand #(
        .PARAMETER_SET ("L1")
    ) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_start               (start),
        .i_hash_data_out       (hdata),
        .i_hash_data_out_valid (hvalid),
        .o_hash_data_out_ready (ready),
        .o_hash_force_done     (force_done),
        .i_hash_force_done_ack (ack),
        .i_r_addr              (r_addr),
        .i_r_rd                (r_rd),
        .o_r                   (o_r),
        .i_eps_addr            (eps_addr),
        .i_eps_rd              (eps_rd),
        .o_eps                 (o_eps),
        .o_busy                (busy),
        .o_done                (done)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    int            consumed = 0;
    int            busy_cnt = 0;
    logic [31:0]   stream [$];
    logic [31:0]   acc_r [$];
    logic [31:0]   acc_eps [$];
    logic [EW-1:0] exp_r [ENTRIES];
    logic [EW-1:0] exp_eps [ENTRIES];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit rejected(input logic [31:0] w, input bit in_r);
`ifdef SIGN_CHAL_REJECT_EN
        return in_r && (w[31:8] == 24'd0);
`else
        return 1'b0 & in_r & w[0];
`endif
    endfunction

    task automatic model_clear();
        stream.delete();
        acc_r.delete();
        acc_eps.delete();
    endtask

    task automatic push_word(input logic [31:0] w);
        stream.push_back(w);
        if (acc_r.size() < N_CHAL) begin
            if (!rejected(w, 1'b1)) acc_r.push_back(w);
        end else if (acc_eps.size() < N_CHAL) begin
            acc_eps.push_back(w);
        end
    endtask

    function automatic bit model_full();
        return acc_eps.size() == N_CHAL;
    endfunction

    task automatic build_model();
        for (int unsigned k = 0; k < N_CHAL; k++) begin
            exp_r[k / T][(k % T) * 32 +: 32]   = acc_r[k];
            exp_eps[k / T][(k % T) * 32 +: 32] = acc_eps[k];
        end
    endtask

    task automatic gen_seq();
        int i = 0;
        model_clear();
        while (!model_full()) begin
            push_word(32'h0100_0000 + 32'(i));
            i++;
        end
        build_model();
    endtask

    task automatic gen_rand();
        logic [31:0] w;
        model_clear();
        while (!model_full()) begin
            w = $urandom;
            if ($urandom_range(0, 7) == 0) w = 32'($urandom_range(0, 255));
            push_word(w);
        end
        build_model();
    endtask

    task automatic gen_s2();
        int i = 0;
        bit ins1 = 1'b0;
        bit ins2 = 1'b0;
        model_clear();
        while (!model_full()) begin
            if (acc_r.size() == 4 && !ins1) begin
                push_word(32'h0000_00FF);
                ins1 = 1'b1;
            end else if (acc_r.size() == N_CHAL && acc_eps.size() == 0 && !ins2) begin
                push_word(32'h0000_0005);
                ins2 = 1'b1;
            end else begin
                push_word(32'h0100_0000 + 32'(i));
                i++;
            end
        end
        build_model();
    endtask

    // mode 0: valid every cycle, 1: every other cycle, 2: random gaps
    task automatic feed(input int mode, input int repulse_at, input int abort_at);
        int it = 0;
        int len;
        bit ok = 1'b0;
        bit rp_done = 1'b0;
        bit vld;
        len = stream.size();
        consumed = 0;
        while (it < 3000) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            start = 1'b0;
            if (it == 0) begin
                check("idle_ready", 128'(ready), 128'(0));
                start = 1'b1;
            end else if (repulse_at >= 0 && consumed == repulse_at && !rp_done) begin
                check("busy_at_repulse", 128'(busy), 128'(1));
                start = 1'b1;
                rp_done = 1'b1;
            end
            if ((abort_at >= 0 && consumed == abort_at) || (stream.size() == 0)) begin
                hvalid = 1'b0;
                start = 1'b0;
                ok = 1'b1;
                break;
            end
            case (mode)
                0:       vld = 1'b1;
                1:       vld = (it % 2 == 0);
                default: vld = ($urandom_range(0, 3) != 0);
            endcase
            hvalid = vld;
            hdata  = vld ? stream[0] : 32'($urandom);
            if (hvalid && ready) begin
                void'(stream.pop_front());
                consumed++;
            end
            it++;
        end
        if (!ok) check("feed_budget", 128'(0), 128'(1));
        else if (abort_at < 0) check("consumed", 128'(consumed), 128'(len));
    endtask

    task automatic finish_run(input int ack_delay);
        int n = 0;
        int hi = 0;
        while (!force_done && n < 100) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            n++;
        end
        check("force_seen", 128'(force_done), 128'(1));
        check("ready_flush", 128'(ready), 128'(0));
        for (int c = 1; c <= ack_delay; c++) begin
            if (force_done) hi++;
            ack = (c == ack_delay);
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        ack = 1'b0;
        check("force_len", 128'(hi), 128'(ack_delay));
        check("force_drop", 128'(force_done), 128'(0));
        check("done_pulse", 128'(done), 128'(1));
        @(negedge clk);
        check("done_once", 128'(done), 128'(0));
        check("busy_end", 128'(busy), 128'(0));
    endtask

    task automatic read_entry(input int unsigned a, output logic [EW-1:0] rv, output logic [EW-1:0] ev);
        @(negedge clk);
        r_addr = AW'(a);
        eps_addr = AW'(a);
        r_rd = 1'b1;
        eps_rd = 1'b1;
        @(negedge clk);
        r_rd = 1'b0;
        eps_rd = 1'b0;
        rv = o_r;
        ev = o_eps;
    endtask

    task automatic verify();
        logic [EW-1:0] rv;
        logic [EW-1:0] ev;
        for (int unsigned e = 0; e < ENTRIES; e++) begin
            read_entry(e, rv, ev);
            check($sformatf("r[%0d]", e), 128'(rv), 128'(exp_r[e]));
            check($sformatf("eps[%0d]", e), 128'(ev), 128'(exp_eps[e]));
        end
        r_addr = '0;
        @(negedge clk);
        check("r_hold", 128'(o_r), 128'(exp_r[ENTRIES-1]));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, 128'(ready), 128'(0));
        check({tag, "_force"}, 128'(force_done), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_done"}, 128'(done), 128'(0));
        check({tag, "_r"}, 128'(o_r), 128'(0));
        check({tag, "_eps"}, 128'(o_eps), 128'(0));
    endtask

    initial begin
        logic [EW-1:0] rv;
        logic [EW-1:0] ev;
        int b1;
        int b3;

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // sequential stream, continuous valid, ack after 5 cycles
        gen_seq();
        busy_cnt = 0;
        feed(0, -1, -1);
        finish_run(5);
        b1 = busy_cnt;
        verify();
        read_entry(0, rv, ev);
        check("s1_r0", 128'(rv), 128'(96'h01000002_01000001_01000000));
        read_entry(16, rv, ev);
        check("s1_eps16", 128'(ev), 128'(96'h01000065_01000064_01000063));

        // valid toggled every other cycle
        gen_seq();
        busy_cnt = 0;
        feed(1, -1, -1);
        finish_run(1);
        b3 = busy_cnt;
        verify();
        check("busy_2x", 128'((b3 * 10 >= b1 * 17) && (b3 * 10 <= b1 * 23)), 128'(1));

        // reset after 30 words, then a clean rerun
        gen_seq();
        feed(0, -1, 30);
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        gen_seq();
        feed(0, -1, -1);
        finish_run(2);
        verify();

        // start re-pulsed during FILL_EPS
        gen_seq();
        feed(0, int'(N_CHAL) + 5, -1);
        finish_run(3);
        verify();
        read_entry(3, rv, ev);
        check("s5_r3", 128'(rv), 128'(96'h0100000B_0100000A_01000009));

`ifdef SIGN_CHAL_REJECT_EN
        gen_s2();
        feed(0, -1, -1);
        check("s2_consumed", 128'(consumed), 128'(103));
        finish_run(1);
        verify();
        read_entry(1, rv, ev);
        check("s2_r1", 128'(rv), 128'(96'h01000005_01000004_01000003));
        read_entry(0, rv, ev);
        check("s2_eps0_l0", 128'(ev[31:0]), 128'(32'h0000_0005));
`endif

        for (int run = 0; run < 4; run++) begin
            gen_rand();
            feed(2, -1, -1);
            finish_run(int'($urandom_range(1, 6)));
            verify();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sign_chal_expand.md
# sign_chal_expand

Challenge-expansion stage that sits directly upstream of `sign_online_sk`. It consumes the 32-bit squeeze stream of `hash_mem_interface` after the H1 digest has been absorbed elsewhere. It packs accepted words into the challenge vectors r and eps: TAU*D_SPLIT entries each, T extension-field lanes of 32 bits per entry. It then serves them to `sign_online_sk` through registered read ports addressed by the online stage.

## Interface
Parameters:
- `PARAMETER_SET`, "L1": selects TAU/D_SPLIT/T; "L3", "L5" supported.
- `FIELD`, "GF256": field tag passed through for consistency; only "GF256" supported.
- `TAU`, 17 / 26 / 34 for L1 / L3 / L5: repetitions.
- `D_SPLIT`, 1 / 2 / 2: split factor.
- `T`, 3 (4 for L5): lanes per entry.
- `N_CHAL`, TAU*D_SPLIT*T: accepted words per vector.
- `ENTRIES`, TAU*D_SPLIT: depth of each vector store.

Ports:
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  one-cycle pulse that arms collection; ignored while `o_busy`.
- `i_hash_data_out`  in  32  squeeze word.
- `i_hash_data_out_valid`  in  1  squeeze word valid.
- `o_hash_data_out_ready`  out  1  word accepted when valid & ready.
- `o_hash_force_done`  out  1  request to terminate the squeeze.
- `i_hash_force_done_ack`  in  1  hash interface acknowledgement.
- `i_r_addr`  in  clog2(ENTRIES)  r read address.
- `i_r_rd`  in  1  r read enable.
- `o_r`  out  T*32  r entry; lane l at bits [l*32 +: 32].
- `i_eps_addr`  in  clog2(ENTRIES)  eps read address.
- `i_eps_rd`  in  1  eps read enable.
- `o_eps`  out  T*32  eps entry; lane layout as `o_r`.
- `o_busy`  out  1  high from the accepted `i_start` until `o_done`.
- `o_done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, FILL_R, FILL_EPS, FLUSH, DONE.
  - IDLE -> FILL_R on `i_start`.
  - FILL_R -> FILL_EPS after N_CHAL accepted r words.
  - FILL_EPS -> FLUSH after N_CHAL eps words.
  - FLUSH -> DONE on `i_hash_force_done_ack`.
  - DONE -> IDLE unconditionally.
- `o_hash_data_out_ready` is high in FILL_R and FILL_EPS only; the block never back-pressures inside those states.
- Packing: the k-th accepted word of a vector goes to entry k/T, lane k%T.
  - A lane counter (0..T-1) and an entry counter (0..ENTRIES-1) sit in the packer.
  - The full entry is written once lane T-1 is accepted.
- Filling, not rejection, decides the state exit: counters count accepted words only.
- `o_hash_force_done` is held high throughout FLUSH until the ack is sampled.
- Stores are two RAMs, depth ENTRIES, width T*32. They are not cleared by reset or `i_start`.
- Reads while `o_busy` return the current RAM contents, which may be partial or stale; no error is flagged.
- If the stream stalls, the FSM waits indefinitely. There is no timeout.

## Timing
- Reset values: all outputs 0; FSM IDLE; counters 0.
- Reset mid-operation returns to IDLE within the same cycle (asynchronous). Partially written RAM entries remain.
- Read latency: 1 cycle. `o_r`/`o_eps` update on the clock edge after `i_*_rd`=1 and hold otherwise.
- Entry write: the RAM is written on the edge following acceptance of lane T-1. It is readable on the port one cycle after that.
- `i_start` and an accepted word in the same cycle: the word is not taken, because ready is low in IDLE.
- `o_done` rises exactly 1 cycle after the ack is sampled.

## Configuration
- `SIGN_CHAL_REJECT_EN` defined: in FILL_R, a valid word with bits [31:8]==0 is consumed (ready high) but discarded. Counters do not advance. This keeps r outside the base-field evaluation set. eps is never filtered.
- Undefined: every word is accepted in both fill states.

## Structure
- Shared package `sign_pkg`:
  - per-PARAMETER_SET constant functions for TAU, D_SPLIT, T;
  - FSM state enum;
  - lane width constant (32).
- One sub-module, `chal_lane_packer`:
  - holds the lane/entry counters and the T*32 assembly register;
  - produces the write strobe and write address.
- It is instantiated once and shared by both fill states; counters are cleared on the transition to FILL_EPS.

## Test plan
1. Rejection off, L1: stream words 0x01000000+i for i=0..101, one per cycle.
   - Read r addr 0 -> {0x01000002,0x01000001,0x01000000}.
   - Read eps addr 16 -> {0x01000065,0x01000064,0x01000063}.
   - Ready falls after word 101; `o_done` pulses one cycle after ack.
2. `SIGN_CHAL_REJECT_EN` set: insert 0x000000FF before r word 4 and 0x00000005 as eps word 0.
   - r entry 1 unchanged versus scenario 1.
   - eps entry 0 lane 0 = 0x00000005.
   - Total consumed words = 103.
3. Valid toggled every other cycle -> identical RAM contents to scenario 1; `o_busy` lasts about 2x longer.
4. `i_rst_n` low after 30 words -> all outputs 0 immediately. A new run then completes with scenario 1 contents.
5. `i_start` re-pulsed during FILL_EPS -> ignored; final contents match scenario 1. An `i_r_rd` addr 3 -> `o_r`={w11,w10,w9} on the next edge.
6. Ack delayed 5 cycles -> `o_hash_force_done` high exactly 5 cycles; ready low; `o_done` follows one cycle after ack.
